// File: rtl/interrupt_ctrl_if.sv
// Pipeline-side signal bundle for the interrupt controller.
// The pipeline/control side (master) drives the decode and request signals.
// The controller (slave) returns stall, flush and redirect controls plus its status.
interface interrupt_ctrl_if #(
  parameter int NUM_IRQ = 3
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               id_valid;
  logic [31:0]        pc_id;
  logic               eret_id;
  logic               branch_ex;
  logic               halt;
  logic               stall_if;
  logic               flush_id;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        epc;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] irq_ack;

  modport master (
    output irq_in, id_valid, pc_id, eret_id, branch_ex, halt,
    input  stall_if, flush_id, redirect, redirect_pc, epc, active, pending, irq_ack
  );

  modport slave (
    input  irq_in, id_valid, pc_id, eret_id, branch_ex, halt,
    output stall_if, flush_id, redirect, redirect_pc, epc, active, pending, irq_ack
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt entry / ERET return sequencer for the five-stage pipeline.
// Rising edges on the request lines are latched as pending requests.
// The highest-priority eligible request cancels the instruction in ID and saves its PC on an EPC stack.
// Older instructions then drain before fetch is redirected to the handler vector.
// ERET pops the stack, retires the innermost level and redirects fetch back to the saved PC.
module interrupt_ctrl #(
  parameter int          NUM_IRQ      = 3,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0800,
  parameter int          VEC_SHIFT    = 4
) (
  input logic             clk,
  input logic             CLR,
  interrupt_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int SP_W  = $clog2(NUM_IRQ + 1);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ENTER  = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   sel_q;
  logic [IDX_W-1:0]   sel;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] active_q;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [31:0]        stack [NUM_IRQ];
  logic [SP_W-1:0]    sp;
  logic [31:0]        epc_top;
  logic [31:0]        vector;
  logic               seen;
  logic               take;
  logic               eret_take;

  assign rise      = bus.irq_in & ~irq_prev;
  assign epc_top   = (sp == '0) ? 32'h0 : stack[sp - SP_W'(1)];
  assign vector    = VEC_BASE + (32'(sel_q) << VEC_SHIFT);
  assign pend_clr  = (state == ENTER && !bus.halt) ? (NUM_IRQ'(1) << sel_q) : '0;
  assign take      = (state == IDLE) && (|eligible) && bus.id_valid && !bus.branch_ex &&
                     !bus.halt && !bus.eret_id;
  assign eret_take = (state == IDLE) && bus.eret_id && bus.id_valid && (|active_q) &&
                     !bus.branch_ex && !bus.halt;

  assign bus.epc     = epc_top;
  assign bus.active  = active_q;
  assign bus.pending = pending_q;

  // Eligible levels are pending, not in service, and above the innermost active level; pick the lowest index.
  always_comb begin
    seen     = 1'b0;
    eligible = '0;
    sel      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      seen        = seen | active_q[i];
      eligible[i] = pending_q[i] & ~seen;
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IDX_W'(i);
    end
  end

  // Pipeline controls decoded from the current state; halt suppresses the one-shot strobes only.
  always_comb begin
    bus.stall_if    = 1'b0;
    bus.flush_id    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.irq_ack     = '0;
    case (state)
      IDLE: begin
        if (take || eret_take) begin
          bus.stall_if = 1'b1;
          bus.flush_id = 1'b1;
        end
      end
      DRAIN: begin
        bus.stall_if = 1'b1;
        bus.flush_id = 1'b1;
      end
      ENTER: begin
        bus.flush_id    = 1'b1;
        bus.redirect_pc = vector;
        if (!bus.halt) begin
          bus.redirect = 1'b1;
          bus.irq_ack  = NUM_IRQ'(1) << sel_q;
        end
      end
      RETURN: begin
        bus.flush_id    = 1'b1;
        bus.redirect_pc = epc_top;
        bus.redirect    = !bus.halt;
      end
      default: ;
    endcase
  end

  // Previous request levels, used to detect rising edges.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) irq_prev <= '0;
    else      irq_prev <= bus.irq_in;
  end

  // Sequencer: pending/active bookkeeping, EPC stack and the entry/return state machine.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      count     <= '0;
      sel_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      sp        <= '0;
      for (int i = 0; i < NUM_IRQ; i++) stack[i] <= 32'h0;
    end else begin
      pending_q <= (pending_q & ~pend_clr) | rise;
      case (state)
        IDLE: begin
          if (eret_take) begin
            state <= RETURN;
          end else if (take) begin
            stack[sp] <= bus.pc_id;
            sp        <= sp + SP_W'(1);
            sel_q     <= sel;
            count     <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.halt) begin
            if (count == CNT_W'(DRAIN_CYCLES - 1)) state <= ENTER;
            else                                   count <= count + CNT_W'(1);
          end
        end
        ENTER: begin
          if (!bus.halt) begin
            active_q[sel_q] <= 1'b1;
            state           <= IDLE;
          end
        end
        RETURN: begin
          if (!bus.halt) begin
            sp       <= sp - SP_W'(1);
            active_q <= active_q & (active_q - NUM_IRQ'(1));
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
